// File: rtl/video_timing_pkg.sv
// Shared timing helpers, preset timing sets and the video bundle type
// consumed by the pattern generators and the TMDS path.
package video_timing_pkg;

    localparam int VTG_COORD_W = 16;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } vtg_timing_t;

    localparam vtg_timing_t SVGA_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol: 1'b1, vs_pol: 1'b1
    };

    localparam vtg_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    typedef struct packed {
        logic                   hs;
        logic                   vs;
        logic                   de;
        logic [VTG_COORD_W-1:0] pixel_x;
        logic [VTG_COORD_W-1:0] pixel_y;
    } vtg_video_t;

    function automatic int axis_total(input int sync, input int bp,
                                      input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis (sync, back porch, active, front porch): a wrapping
// counter plus the region decodes of its current value.
module vtg_axis_counter
    import video_timing_pkg::*;
#(
    parameter int SYNC   = 1,
    parameter int BP     = 1,
    parameter int ACTIVE = 1,
    parameter int FP     = 1,
    parameter int W      = cnt_width(axis_total(SYNC, BP, ACTIVE, FP))
) (
    input  logic         pixelClk,
    input  logic         reset,
    input  logic         clear,
    input  logic         advance,
    output logic         wrap,
    output logic         atStart,
    output logic         inSync,
    output logic         inActive,
    output logic [W-1:0] activeIdx
);

    localparam int TOTAL     = axis_total(SYNC, BP, ACTIVE, FP);
    localparam int ACT_START = SYNC + BP;
    localparam int ACT_END   = ACT_START + ACTIVE;
    localparam int XW        = W + 1;

    logic [W-1:0]  count_reg;
    logic [W-1:0]  count_next;
    logic [XW-1:0] count_ext;
    logic          at_last;

    // One spare bit so region bounds equal to 2**W still compare correctly.
    assign count_ext = {1'b0, count_reg};
    assign at_last   = (count_ext == XW'(TOTAL - 1));

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (advance) begin
            count_next = at_last ? '0 : count_reg + W'(1);
        end
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign wrap      = advance && at_last && !clear;
    assign atStart   = (count_ext == '0);
    assign inSync    = (count_ext < XW'(SYNC));
    assign inActive  = (count_ext >= XW'(ACT_START)) && (count_ext < XW'(ACT_END));
    assign activeIdx = W'(count_ext - XW'(ACT_START));

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hs/vs/de, active coordinates and line/frame
// pulses, all registered. Optional frameCount output under VTG_FRAME_CNT_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_800x600_60.h_active,
    parameter int H_FP     = SVGA_800x600_60.h_fp,
    parameter int H_SYNC   = SVGA_800x600_60.h_sync,
    parameter int H_BP     = SVGA_800x600_60.h_bp,
    parameter int V_ACTIVE = SVGA_800x600_60.v_active,
    parameter int V_FP     = SVGA_800x600_60.v_fp,
    parameter int V_SYNC   = SVGA_800x600_60.v_sync,
    parameter int V_BP     = SVGA_800x600_60.v_bp,
    parameter bit HS_POL   = SVGA_800x600_60.hs_pol,
    parameter bit VS_POL   = SVGA_800x600_60.vs_pol,
    parameter int X_W      = 11,
    parameter int Y_W      = 11
) (
    input  logic           pixelClk,
    input  logic           reset,
    input  logic           enable,
    output logic           stopped,
    output logic           hs,
    output logic           vs,
    output logic           de,
    output logic [X_W-1:0] pixelX,
    output logic [Y_W-1:0] pixelY,
    output logic           frameStart,
    output logic           lineStart
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]    frameCount
`endif
);

    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic   run;

    logic          h_wrap, h_start, h_sync, h_active;
    logic [HW-1:0] h_idx;
    logic          frame_end, v_start, v_sync, v_active;
    logic [VW-1:0] v_idx;

    logic           hs_reg, hs_next;
    logic           vs_reg, vs_next;
    logic           de_reg, de_next;
    logic [X_W-1:0] pixel_x_reg, pixel_x_next;
    logic [Y_W-1:0] pixel_y_reg, pixel_y_next;
    logic           frame_start_reg, frame_start_next;
    logic           line_start_reg, line_start_next;
    logic           stopped_reg, stopped_next;

    assign run = (state_reg == RUN);

    vtg_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .W      (HW)
    ) u_h_axis (
        .pixelClk  (pixelClk),
        .reset     (reset),
        .clear     (!run),
        .advance   (run),
        .wrap      (h_wrap),
        .atStart   (h_start),
        .inSync    (h_sync),
        .inActive  (h_active),
        .activeIdx (h_idx)
    );

    // The vertical wrap coincides with the last cycle of the frame.
    vtg_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .W      (VW)
    ) u_v_axis (
        .pixelClk  (pixelClk),
        .reset     (reset),
        .clear     (!run),
        .advance   (h_wrap),
        .wrap      (frame_end),
        .atStart   (v_start),
        .inSync    (v_sync),
        .inActive  (v_active),
        .activeIdx (v_idx)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (frame_end && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hs_next          = ~HS_POL;
        vs_next          = ~VS_POL;
        de_next          = 1'b0;
        pixel_x_next     = '0;
        pixel_y_next     = '0;
        frame_start_next = 1'b0;
        line_start_next  = 1'b0;
        stopped_next     = (state_next == IDLE);
        if (run) begin
            hs_next          = h_sync ? HS_POL : ~HS_POL;
            vs_next          = v_sync ? VS_POL : ~VS_POL;
            de_next          = h_active && v_active;
            line_start_next  = h_start;
            frame_start_next = h_start && v_start;
            if (de_next) begin
                pixel_x_next = X_W'(h_idx);
                pixel_y_next = Y_W'(v_idx);
            end
        end
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            hs_reg          <= ~HS_POL;
            vs_reg          <= ~VS_POL;
            de_reg          <= 1'b0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            stopped_reg     <= 1'b1;
        end else begin
            state_reg       <= state_next;
            hs_reg          <= hs_next;
            vs_reg          <= vs_next;
            de_reg          <= de_next;
            pixel_x_reg     <= pixel_x_next;
            pixel_y_reg     <= pixel_y_next;
            frame_start_reg <= frame_start_next;
            line_start_reg  <= line_start_next;
            stopped_reg     <= stopped_next;
        end
    end

    assign hs         = hs_reg;
    assign vs         = vs_reg;
    assign de         = de_reg;
    assign pixelX     = pixel_x_reg;
    assign pixelY     = pixel_y_reg;
    assign frameStart = frame_start_reg;
    assign lineStart  = line_start_reg;
    assign stopped    = stopped_reg;

`ifdef VTG_FRAME_CNT_EN
    // Counts in step with the frameStart register, so the new value and the pulse appear together.
    logic [15:0] frame_count_reg;

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            frame_count_reg <= '0;
        end else if (frame_start_next) begin
            frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    assign frameCount = frame_count_reg;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised enable/reset stimulus on two timing sets; a raster-position
// reference model feeds per-DUT scoreboard queues checked by a monitor.
`timescale 1ns/1ps
module tb_video_timing_gen;

    typedef struct packed {
        logic        stopped;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ls;
        logic [15:0] px;
        logic [15:0] py;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    logic pixelClk = 1'b0;
    logic reset    = 1'b0;
    logic enable   = 1'b0;

    always #5 pixelClk = ~pixelClk;

    logic        stopped_a, hs_a, vs_a, de_a, fs_a, ls_a;
    logic [1:0]  px_a, py_a;
    logic [15:0] fc_a;
    logic        stopped_b, hs_b, vs_b, de_b, fs_b, ls_b;
    logic [3:0]  px_b;
    logic [2:0]  py_b;
    logic [15:0] fc_b;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .X_W(2), .Y_W(2)
    ) u_a (
        .pixelClk   (pixelClk),
        .reset      (reset),
        .enable     (enable),
        .stopped    (stopped_a),
        .hs         (hs_a),
        .vs         (vs_a),
        .de         (de_a),
        .pixelX     (px_a),
        .pixelY     (py_a),
        .frameStart (fs_a),
        .lineStart  (ls_a)
`ifdef VTG_FRAME_CNT_EN
        ,
        .frameCount (fc_a)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .X_W(4), .Y_W(3)
    ) u_b (
        .pixelClk   (pixelClk),
        .reset      (reset),
        .enable     (enable),
        .stopped    (stopped_b),
        .hs         (hs_b),
        .vs         (vs_b),
        .de         (de_b),
        .pixelX     (px_b),
        .pixelY     (py_b),
        .frameStart (fs_b),
        .lineStart  (ls_b)
`ifdef VTG_FRAME_CNT_EN
        ,
        .frameCount (fc_b)
`endif
    );

`ifndef VTG_FRAME_CNT_EN
    assign fc_a = 16'd0;
    assign fc_b = 16'd0;
`endif

    obs_t act [2];
    assign act[0] = {stopped_a, hs_a, vs_a, de_a, fs_a, ls_a, 16'(px_a), 16'(py_a), fc_a};
    assign act[1] = {stopped_b, hs_b, vs_b, de_b, fs_b, ls_b, 16'(px_b), 16'(py_b), fc_b};

    cfg_t        cfg [2];
    int          run_m [2];
    int          pos_m [2];
    logic [15:0] fc_m [2];
    obs_t        q0 [$];
    obs_t        q1 [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic cmp(input string nm, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    task automatic cmp_bit(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
        end
    endtask

    function automatic int frame_len(input int d);
        return (cfg[d].hs + cfg[d].hb + cfg[d].ha + cfg[d].hf) *
               (cfg[d].vs + cfg[d].vb + cfg[d].va + cfg[d].vf);
    endfunction

    function automatic obs_t idle_obs(input int d, input logic stop);
        obs_t o;
        o         = '0;
        o.stopped = stop;
        o.hs      = ~cfg[d].hp;
        o.vs      = ~cfg[d].vp;
`ifdef VTG_FRAME_CNT_EN
        o.fc      = fc_m[d];
`endif
        return o;
    endfunction

    // Outputs for raster position pos (pixels since the start of the frame).
    function automatic obs_t decode(input int d, input int pos);
        obs_t o;
        int ht, h, v, x0, y0;
        ht   = cfg[d].hs + cfg[d].hb + cfg[d].ha + cfg[d].hf;
        h    = pos % ht;
        v    = pos / ht;
        x0   = cfg[d].hs + cfg[d].hb;
        y0   = cfg[d].vs + cfg[d].vb;
        o    = '0;
        o.hs = (h < cfg[d].hs) ? cfg[d].hp : ~cfg[d].hp;
        o.vs = (v < cfg[d].vs) ? cfg[d].vp : ~cfg[d].vp;
        o.de = (h >= x0) && (h < x0 + cfg[d].ha) && (v >= y0) && (v < y0 + cfg[d].va);
        if (o.de) begin
            o.px = 16'(h - x0);
            o.py = 16'(v - y0);
        end
        o.ls = (h == 0);
        o.fs = (pos == 0);
        return o;
    endfunction

    task automatic push(input int d, input obs_t o);
        if (d == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    // Expected outputs right after a clock edge, given enable/reset at that edge.
    task automatic model_step(input int d, input logic en, input logic rst);
        obs_t o;
        if (rst) begin
            run_m[d] = 0;
            pos_m[d] = 0;
            fc_m[d]  = 16'd0;
            o = idle_obs(d, 1'b1);
        end else if (run_m[d] == 0) begin
            o = idle_obs(d, 1'b1);
            if (en) begin
                run_m[d] = 1;
                pos_m[d] = 0;
            end
        end else begin
            o = decode(d, pos_m[d]);
            if (o.fs) fc_m[d] = fc_m[d] + 16'd1;
            if (pos_m[d] == frame_len(d) - 1) begin
                pos_m[d] = 0;
                if (!en) run_m[d] = 0;
            end else begin
                pos_m[d]++;
            end
`ifdef VTG_FRAME_CNT_EN
            o.fc = fc_m[d];
`endif
        end
        o.stopped = (run_m[d] == 0);
        push(d, o);
    endtask

    task automatic cycle();
        @(posedge pixelClk);
        for (int d = 0; d < 2; d++) model_step(d, enable, reset);
        #3;
    endtask

    // Asserted between edges: outputs must drop at once, not at the next edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            run_m[d] = 0;
            pos_m[d] = 0;
            fc_m[d]  = 16'd0;
        end
        if (q0.size() > 0) void'(q0.pop_back());
        if (q1.size() > 0) void'(q1.pop_back());
        push(0, idle_obs(0, 1'b1));
        push(1, idle_obs(1, 1'b1));
        cmp("async_rst_a", act[0], idle_obs(0, 1'b1));
        cmp("async_rst_b", act[1], idle_obs(1, 1'b1));
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge pixelClk);
            if (q0.size() > 0) cmp("sb_a", act[0], q0.pop_front());
            if (q1.size() > 0) cmp("sb_b", act[1], q1.pop_front());
        end
    end

    initial begin
        cfg[0] = '{ha: 4,  hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};
        cfg[1] = '{ha: 10, hf: 2, hs: 3, hb: 4, va: 6, vf: 1, vs: 2, vb: 2, hp: 1'b0, vp: 1'b0};
        for (int d = 0; d < 2; d++) begin
            run_m[d] = 0;
            pos_m[d] = 0;
            fc_m[d]  = 16'd0;
        end

        #1 reset = 1'b1;
        repeat (2) @(posedge pixelClk);
        #3;
        cmp("rst_a", act[0], idle_obs(0, 1'b1));
        cmp("rst_b", act[1], idle_obs(1, 1'b1));
        cmp_bit("rst_hs_b_idle_high", hs_b, 1'b1);
        reset = 1'b0;

        // Continuous run across several frames of both timing sets.
        repeat (5) cycle();
        enable = 1'b1;
        repeat (700) cycle();

        // Random enable levels with occasional mid-frame resets.
        for (int s = 0; s < 40; s++) begin
            int n;
            enable = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 250);
            for (int i = 0; i < n; i++) begin
                cycle();
                if ($urandom_range(0, 199) == 0) pulse_reset();
            end
        end

        // Reset with enable held: frameStart two edges after release.
        enable = 1'b1;
        repeat (20) cycle();
        pulse_reset();
        cycle();
        cmp_bit("fs_edge1_a", fs_a, 1'b0);
        cmp_bit("stopped_edge1_b", stopped_b, 1'b0);
        cycle();
        cmp_bit("fs_edge2_a", fs_a, 1'b1);
        cmp_bit("fs_edge2_b", fs_b, 1'b1);

        // Drop enable on line 10 of timing set B; the frame must still finish.
        repeat (194) cycle();
        enable = 1'b0;
        repeat (400) cycle();
        cmp_bit("idle_stopped_b", stopped_b, 1'b1);
        cmp_bit("idle_hs_b", hs_b, 1'b1);
        cmp_bit("idle_de_a", de_a, 1'b0);

        repeat (3) @(negedge pixelClk);
        cmp_bit("sb_drained", (q0.size() == 0) && (q1.size() == 0), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
